// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_XFER = 2'd1,
    I_LO   = 2'd2,
    I_HI   = 2'd3
  } arb_state_e;

  // Fetch beats always move a full halfword.
  localparam logic [1:0]  BE_FULL    = 2'b11;
  // Byte distance from the low to the high opcode half.
  localparam logic [15:0] FETCH_STEP = 16'd2;

endpackage

// File: rtl/mem_arb_fetch_buf.sv
// mem_arb_fetch_buf: opcode half assembly, fetch address register and
// redirect compare. With MEM_ARB_FETCH_REUSE_EN defined it also keeps a
// one-entry reuse buffer tagged with the last delivered fetch address.
module mem_arb_fetch_buf
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        a_rst,
  input  logic        i_req,
  input  logic [15:0] i_pc,
  input  logic        i_grant,      // fetch granted to the bus this cycle
  input  logic        i_lo_ack,     // low opcode half returned
  input  logic        i_hi_ack,     // high opcode half returned
  input  logic [15:0] i_rdata,
`ifdef MEM_ARB_FETCH_REUSE_EN
  input  logic        i_hit_take,   // fetch served from the reuse entry
  input  logic        i_dwr_grant,  // data write granted this cycle
  input  logic [15:0] i_daddr,
  output logic        o_hit,
`endif
  output logic [15:0] o_pc_hi,
  output logic [31:0] o_opcode,
  output logic        o_rdy
);

  logic [15:0] r_pc_q;
  logic [15:0] r_lo;
  logic [31:0] r_opcode;
  logic        r_rdy;
  logic        w_match;
  logic        w_rdy_d;

  // The core still wants the address we fetched; otherwise it redirected.
  assign w_match  = i_req && (i_pc == r_pc_q);
  assign o_pc_hi  = r_pc_q + FETCH_STEP;
  assign o_opcode = r_opcode;
  assign o_rdy    = r_rdy;

`ifdef MEM_ARB_FETCH_REUSE_EN
  logic        r_valid;
  logic [15:0] r_tag;
  logic [15:0] w_tag_hi;
  logic        w_inval;

  assign w_tag_hi = r_tag + FETCH_STEP;
  assign w_inval  = i_dwr_grant &&
                    ((i_daddr[15:1] == r_tag[15:1]) || (i_daddr[15:1] == w_tag_hi[15:1]));
  assign o_hit    = r_valid && i_req && (i_pc == r_tag);
  assign w_rdy_d  = (i_hi_ack && w_match) || i_hit_take;

  // Reuse entry: filled on each delivered opcode, dropped by writes over either half.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (i_hi_ack && w_match) begin
      r_valid <= 1'b1;
      r_tag   <= r_pc_q;
    end else if (w_inval) begin
      r_valid <= 1'b0;
    end
  end
`else
  assign w_rdy_d = i_hi_ack && w_match;
`endif

  // Fetch address, opcode halves and the one-cycle ready pulse.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_pc_q   <= '0;
      r_lo     <= '0;
      r_opcode <= '0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= w_rdy_d;
      if (i_grant) begin
        r_pc_q <= i_pc;
      end
      if (i_lo_ack) begin
        r_lo <= i_rdata;
      end
      // A redirected fetch leaves the previous opcode visible.
      if (i_hi_ack && w_match) begin
        r_opcode <= {i_rdata, r_lo};
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 16-bit memory bus between the two-beat opcode
// fetch port and the single-beat data port. Data has priority, limited by a
// streak counter so a pending fetch is served after MAX_D_STREAK data grants.
// Optional feature macro: MEM_ARB_FETCH_REUSE_EN (one-entry opcode reuse).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 3,
  parameter int unsigned CNT_W        = 2  // 2**CNT_W must exceed MAX_D_STREAK
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        i_req,
  input  logic [15:0] i_pc,
  output logic [31:0] i_opcode,
  output logic        i_rdy,
  input  logic        d_assert,
  input  logic        d_cmd,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        d_be0,
  input  logic        d_be1,
  output logic [15:0] d_rdata,
  output logic        d_rdy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  output logic [1:0]  bus_be,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata
);

  localparam logic [CNT_W-1:0] MaxStreak = CNT_W'(MAX_D_STREAK);
  localparam logic [CNT_W-1:0] StreakSat = '1;

  arb_state_e       r_state;
  arb_state_e       w_state_d;
  logic [CNT_W-1:0] r_streak;
  logic             r_i_at_grant;
  logic             r_d_rdy;
  logic [15:0]      r_d_rdata;
  logic             r_bus_req;
  logic             r_bus_we;
  logic [15:0]      r_bus_addr;
  logic [15:0]      r_bus_wdata;
  logic [1:0]       r_bus_be;

  logic             w_ack;
  logic             w_block;
  logic             w_d_wins;
  logic             w_hit;
  logic             w_grant_d;
  logic             w_grant_i;
  logic             w_hit_take;
  logic             w_d_ack;
  logic             w_lo_ack;
  logic             w_hi_ack;
  logic [15:0]      w_pc_hi;

  // An ack without an outstanding request is noise from the fabric.
  assign w_ack    = bus_ack && r_bus_req;
  // Requests seen during a ready pulse are the ones just served.
  assign w_block  = r_d_rdy || i_rdy;
  assign w_d_wins = d_assert && (!i_req || (r_streak < MaxStreak));

  assign d_rdy     = r_d_rdy;
  assign d_rdata   = r_d_rdata;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_be    = r_bus_be;

`ifdef MEM_ARB_FETCH_REUSE_EN
  logic w_dwr_grant;
  assign w_dwr_grant = w_grant_d && d_cmd;
`else
  assign w_hit = 1'b0;
`endif

  mem_arb_fetch_buf u_fetch_buf (
    .clk         (clk),
    .a_rst       (a_rst),
    .i_req       (i_req),
    .i_pc        (i_pc),
    .i_grant     (w_grant_i),
    .i_lo_ack    (w_lo_ack),
    .i_hi_ack    (w_hi_ack),
    .i_rdata     (bus_rdata),
`ifdef MEM_ARB_FETCH_REUSE_EN
    .i_hit_take  (w_hit_take),
    .i_dwr_grant (w_dwr_grant),
    .i_daddr     (d_addr),
    .o_hit       (w_hit),
`endif
    .o_pc_hi     (w_pc_hi),
    .o_opcode    (i_opcode),
    .o_rdy       (i_rdy)
  );

  // State register.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Arbitration and transfer sequencing.
  always_comb begin
    w_state_d  = r_state;
    w_grant_d  = 1'b0;
    w_grant_i  = 1'b0;
    w_hit_take = 1'b0;
    w_d_ack    = 1'b0;
    w_lo_ack   = 1'b0;
    w_hi_ack   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_block) begin
          if (w_d_wins) begin
            w_grant_d = 1'b1;
            w_state_d = D_XFER;
          end else if (i_req) begin
            if (w_hit) begin
              w_hit_take = 1'b1;
            end else begin
              w_grant_i = 1'b1;
              w_state_d = I_LO;
            end
          end
        end
      end
      D_XFER: begin
        if (w_ack) begin
          w_d_ack   = 1'b1;
          w_state_d = IDLE;
        end
      end
      I_LO: begin
        if (w_ack) begin
          w_lo_ack  = 1'b1;
          w_state_d = I_HI;
        end
      end
      I_HI: begin
        if (w_ack) begin
          w_hi_ack  = 1'b1;
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Registered bus command; request is held across both fetch beats.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
    end else if (w_grant_d) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= d_cmd;
      r_bus_addr  <= d_addr;
      r_bus_wdata <= d_wdata;
      r_bus_be    <= {d_be1, d_be0};
    end else if (w_grant_i) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= i_pc;
      r_bus_be    <= BE_FULL;
    end else if (w_lo_ack) begin
      r_bus_addr  <= w_pc_hi;
    end else if (w_d_ack || w_hi_ack) begin
      r_bus_req   <= 1'b0;
    end
  end

  // Data completion, read data capture and the data streak counter.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_d_rdy      <= 1'b0;
      r_d_rdata    <= '0;
      r_i_at_grant <= 1'b0;
      r_streak     <= '0;
    end else begin
      r_d_rdy <= w_d_ack;
      if (w_d_ack && !r_bus_we) begin
        r_d_rdata <= bus_rdata;
      end
      if (w_grant_d) begin
        r_i_at_grant <= i_req;
      end
      if (w_d_ack) begin
        if (!r_i_at_grant) begin
          r_streak <= '0;
        end else if (r_streak != StreakSat) begin
          r_streak <= r_streak + 1'b1;
        end
      end else if (w_hi_ack || w_hit_take) begin
        r_streak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a bus fabric model and scoreboard
// queues for bus beats, data read results and delivered opcodes.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } beat_t;

  logic        clk = 1'b0;
  logic        a_rst = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_pc = '0;
  logic [31:0] i_opcode;
  logic        i_rdy;
  logic        d_assert = 1'b0;
  logic        d_cmd = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_be0 = 1'b0;
  logic        d_be1 = 1'b0;
  logic [15:0] d_rdata;
  logic        d_rdy;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [1:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = '0;

  int          total = 0;
  int          bad = 0;
  int          ack_wait = 0;
  int          wcnt = 0;
  logic        spur = 1'b0;
  logic [15:0] mem [0:32767];
  beat_t       exp_beats[$];
  logic [15:0] exp_dr[$];
  logic [31:0] exp_op[$];
  logic [15:0] model_dr = '0;
  int          n;
  int          n3;

  mem_port_arbiter dut (
    .clk       (clk),
    .a_rst     (a_rst),
    .i_req     (i_req),
    .i_pc      (i_pc),
    .i_opcode  (i_opcode),
    .i_rdy     (i_rdy),
    .d_assert  (d_assert),
    .d_cmd     (d_cmd),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be0     (d_be0),
    .d_be1     (d_be1),
    .d_rdata   (d_rdata),
    .d_rdy     (d_rdy),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fabric model plus output monitor, all on the falling edge.
  always @(negedge clk) begin
    beat_t b;
    if (!bus_req || bus_ack) wcnt = 0;
    if (bus_req && wcnt >= ack_wait) begin
      bus_ack   = 1'b1;
      bus_rdata = mem[bus_addr[15:1]];
      chk("beat_expected", 32'(exp_beats.size() > 0), 1);
      if (exp_beats.size() > 0) begin
        b = exp_beats.pop_front();
        chk("beat_we", 32'(bus_we), 32'(b.we));
        chk("beat_addr", 32'(bus_addr), 32'(b.addr));
        chk("beat_be", 32'(bus_be), 32'(b.be));
        if (bus_we) chk("beat_wdata", 32'(bus_wdata), 32'(b.wdata));
      end
      if (bus_we) begin
        if (bus_be[0]) mem[bus_addr[15:1]][7:0]  = bus_wdata[7:0];
        if (bus_be[1]) mem[bus_addr[15:1]][15:8] = bus_wdata[15:8];
      end
    end else begin
      bus_ack   = spur & ~bus_req;
      bus_rdata = 16'h0;
      if (bus_req) wcnt++;
    end
    if (d_rdy) begin
      chk("d_rdy_expected", 32'(exp_dr.size() > 0), 1);
      if (exp_dr.size() > 0) chk("d_rdata", 32'(d_rdata), 32'(exp_dr.pop_front()));
    end
    if (i_rdy) begin
      chk("i_rdy_expected", 32'(exp_op.size() > 0), 1);
      if (exp_op.size() > 0) chk("i_opcode", i_opcode, exp_op.pop_front());
    end
  end

  task automatic push_beat(input logic we, input logic [15:0] a, input logic [15:0] wd,
                           input logic [1:0] be);
    beat_t b;
    b.we = we; b.addr = a; b.wdata = wd; b.be = be;
    exp_beats.push_back(b);
  endtask

  task automatic push_fetch(input logic [15:0] pc);
    push_beat(1'b0, pc, 16'h0, 2'b11);
    push_beat(1'b0, pc + 16'd2, 16'h0, 2'b11);
  endtask

  // Data master: holds the request until d_rdy, then drops it.
  task automatic dacc(input logic we, input logic [15:0] a, input logic [15:0] wd,
                      input logic [1:0] be, input logic [15:0] rd_exp);
    int k;
    d_cmd = we; d_addr = a; d_wdata = wd; {d_be1, d_be0} = be; d_assert = 1'b1;
    if (we) begin
      exp_dr.push_back(model_dr);
    end else begin
      exp_dr.push_back(rd_exp);
      model_dr = rd_exp;
    end
    k = 0;
    do begin @(negedge clk); k++; end while (!d_rdy && k < 60);
    chk("d_rdy_timeout", 32'(d_rdy), 1);
    d_assert = 1'b0;
  endtask

  task automatic wait_irdy(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!i_rdy && k < 60);
    chk("i_rdy_timeout", 32'(i_rdy), 1);
  endtask

  task automatic fetch(input logic [15:0] pc, input logic [31:0] op, output int k);
    i_pc = pc; i_req = 1'b1;
    exp_op.push_back(op);
    wait_irdy(k);
    i_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0;
    mem[16'h1234 >> 1] = 16'hBEEF;
    mem[16'h0100 >> 1] = 16'h1111;
    mem[16'h0102 >> 1] = 16'h2222;
    mem[16'h0200 >> 1] = 16'h5555;
    mem[16'h0202 >> 1] = 16'h6666;
    mem[16'h0300 >> 1] = 16'h3333;
    mem[16'h0302 >> 1] = 16'h4444;
    mem[16'h2002 >> 1] = 16'hFFFF;

    // Reset values
    #3;
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_outs", 32'(|{i_opcode, i_rdy, d_rdata, d_rdy, bus_we, bus_addr, bus_wdata, bus_be}), 0);
    @(negedge clk); @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);

    // 1: single data read, ack in the second bus cycle
    ack_wait = 1;
    push_beat(1'b0, 16'h1234, 16'h0, 2'b11);
    exp_dr.push_back(16'hBEEF); model_dr = 16'hBEEF;
    d_cmd = 1'b0; d_addr = 16'h1234; d_wdata = 16'h0; d_be0 = 1'b1; d_be1 = 1'b1;
    d_assert = 1'b1;
    @(negedge clk); chk("t1_bus_req_lat", 32'(bus_req), 1);
    @(negedge clk); chk("t1_d_rdy_early", 32'(d_rdy), 0);
    @(negedge clk); chk("t1_d_rdy", 32'(d_rdy), 1);
    chk("t1_d_rdata", 32'(d_rdata), 32'h0000_BEEF);
    d_assert = 1'b0;
    @(negedge clk); chk("t1_d_rdy_pulse", 32'(d_rdy), 0);
    chk("t1_bus_idle", 32'(bus_req), 0);

    // 2: fetch only, zero-wait beats
    ack_wait = 0;
    push_fetch(16'h0100);
    exp_op.push_back(32'h2222_1111);
    i_pc = 16'h0100; i_req = 1'b1;
    @(negedge clk); chk("t2_lo_addr", 32'(bus_addr), 32'h0100);
    chk("t2_lo_req", 32'(bus_req), 1);
    @(negedge clk); chk("t2_hi_addr", 32'(bus_addr), 32'h0102);
    chk("t2_hi_req", 32'(bus_req), 1);
    @(negedge clk); chk("t2_i_rdy", 32'(i_rdy), 1);
    i_req = 1'b0;
    @(negedge clk); chk("t2_i_rdy_pulse", 32'(i_rdy), 0);

    // 3: fairness, three data grants then the fetch, then data again
    push_beat(1'b1, 16'h2000, 16'hA5A5, 2'b11);
    push_beat(1'b0, 16'h2000, 16'h0, 2'b11);
    push_beat(1'b1, 16'h2002, 16'h1234, 2'b01);
    push_fetch(16'h0300);
    push_beat(1'b0, 16'h2002, 16'h0, 2'b11);
    fork
      begin
        dacc(1'b1, 16'h2000, 16'hA5A5, 2'b11, 16'h0);
        dacc(1'b0, 16'h2000, 16'h0, 2'b11, 16'hA5A5);
        dacc(1'b1, 16'h2002, 16'h1234, 2'b01, 16'h0);
        dacc(1'b0, 16'h2002, 16'h0, 2'b11, 16'hFF34);
      end
      fetch(16'h0300, 32'h4444_3333, n3);
    join
    @(negedge clk);
    chk("t3_beats_done", 32'(exp_beats.size()), 0);

    // 4: redirect during the high beat
    push_fetch(16'h0100);
    push_fetch(16'h0200);
    exp_op.push_back(32'h6666_5555);
    i_pc = 16'h0100; i_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus_req && bus_addr == 16'h0102) && n < 20);
    chk("t4_reach_hi", 32'(bus_req && bus_addr == 16'h0102), 1);
    i_pc = 16'h0200;
    @(negedge clk);
    chk("t4_no_i_rdy", 32'(i_rdy), 0);
    chk("t4_opcode_kept", i_opcode, 32'h4444_3333);
    wait_irdy(n);
    i_req = 1'b0;
    @(negedge clk);

    // 5: reset while the low fetch beat is outstanding
    ack_wait = 1000;
    i_pc = 16'h0500; i_req = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("t5_req_pre", 32'(bus_req), 1);
    chk("t5_addr_pre", 32'(bus_addr), 32'h0500);
    #2 a_rst = 1'b0;
    #1;
    chk("t5_req_rst", 32'(bus_req), 0);
    chk("t5_outs_rst", 32'(|{i_opcode, i_rdy, d_rdata, d_rdy, bus_we, bus_addr, bus_wdata, bus_be}), 0);
    i_req = 1'b0;
    model_dr = 16'h0;
    @(negedge clk);
    a_rst = 1'b1; ack_wait = 0; spur = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t5_idle_req", 32'(bus_req), 0);
      chk("t5_idle_rdy", 32'(d_rdy | i_rdy), 0);
    end
    spur = 1'b0;
    @(negedge clk);

    // 6: refetch of the same address, then after a write over its high half
    push_fetch(16'h0100);
    fetch(16'h0100, 32'h2222_1111, n);
    chk("t6_first_lat", 32'(n), 3);
    @(negedge clk);
`ifdef MEM_ARB_FETCH_REUSE_EN
    fetch(16'h0100, 32'h2222_1111, n);
    chk("t6_reuse_lat", 32'(n), 1);
`else
    push_fetch(16'h0100);
    fetch(16'h0100, 32'h2222_1111, n);
    chk("t6_refetch_lat", 32'(n), 3);
`endif
    @(negedge clk);
    push_beat(1'b1, 16'h0102, 16'h7777, 2'b11);
    dacc(1'b1, 16'h0102, 16'h7777, 2'b11, 16'h0);
    @(negedge clk);
    push_fetch(16'h0100);
    fetch(16'h0100, 32'h7777_1111, n);
    chk("t6_after_wr_lat", 32'(n), 3);
    @(negedge clk); @(negedge clk);

    chk("end_beats_left", 32'(exp_beats.size()), 0);
    chk("end_dr_left", 32'(exp_dr.size()), 0);
    chk("end_op_left", 32'(exp_op.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
